svn_scan_ctrl: RTL and testbench

Refresh controller for the 8-digit multiplexed seven-segment display. Holds a 32-bit hex value (eight nibbles) and per-digit decimal-point mask, time-multiplexes one digit at a time onto the shared segment decoder and drives the active-low anode lines. New values arrive through a valid/ready handshake and are committed only at a frame boundary, so the display never tears. An inter-digit blanking window suppresses ghosting, and leading-zero suppression is optional.

---
 rtl/svn_pkg.sv | 16 +
 rtl/svn_tick_gen.sv | 28 ++
 rtl/svn_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_svn_scan_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/svn_pkg.sv
// Shared constants and types for the seven-segment scan controller family.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package svn_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam int         IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [7:0] AN_OFF     = 8'hFF;

  // Per-slot scan phase: anodes dark (BLANK) or driving the current digit (SHOW).
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/svn_tick_gen.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and flags the last count as tick.
// Latency: tick is combinational from the registered count.
// Backpressure: none; runs every cycle.
module svn_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [$clog2(TICK_DIV)-1:0] cnt,
  output logic                        tick
);

  localparam int CW = $clog2(TICK_DIV);

  assign tick = (cnt == CW'(TICK_DIV - 1));

  // Prescaler count, wrapping at the end of every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/svn_scan_ctrl.sv
// Multiplexed 8-digit seven-segment refresh with tear-free frame-boundary commit.
// Latency: outputs registered, one cycle behind state; writes visible after next 7->0 wrap.
// Backpressure: wr_ready low while the single pending buffer holds an uncommitted value.
module svn_scan_ctrl
  import svn_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 2000
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic        dp_n,
  output logic [7:0]  AN,
  output logic        frame_done
);

  localparam int CW = $clog2(TICK_DIV);
  // Last count of the blanking window; unused when there is no blanking.
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  logic [CW-1:0]    cnt;
  logic             tick;
  scan_state_t      state;
  logic [IDX_W-1:0] idx;
  logic [31:0]      act_val;
  logic [7:0]       act_dp;
  logic [31:0]      pend_val;
  logic [7:0]       pend_dp;
  logic             pend_full;
  logic             blank_end;
  logic             frame_end;
  logic [7:0]       supp;
  logic             show;

  // Digits above the highest nonzero nibble are marked; digit 0 is never marked
  // so an all-zero value still shows a single "0".
  function automatic logic [7:0] lz_suppress(input logic [31:0] val);
    logic [7:0] m;
    logic       seen;
    m    = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      seen = seen | (val[4*i +: 4] != 4'd0);
      m[i] = ~seen;
    end
    return m;
  endfunction

  svn_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (sys_rst_n),
    .cnt   (cnt),
    .tick  (tick)
  );

  assign wr_ready  = ~pend_full;
  assign frame_end = tick && (idx == IDX_W'(NUM_DIGITS - 1));
  assign blank_end = (BLANK_CYC == 0) || (cnt == BLANK_LAST);
  assign supp      = blank_lz ? lz_suppress(act_val) : 8'h00;
  assign show      = (state == SHOW) && !supp[idx];

  // Scan FSM, slot index and the registered display outputs.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= BLANK;
      idx        <= '0;
      AN         <= AN_OFF;
      dp_n       <= 1'b1;
      digit      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;

      // A suppressed slot looks exactly like a blanking window; digit keeps its value.
      if (show) begin
        AN    <= ~(8'h01 << idx);
        digit <= act_val[{idx, 2'b00} +: 4];
        dp_n  <= ~act_dp[idx];
      end else begin
        AN    <= AN_OFF;
        dp_n  <= 1'b1;
      end

      if (tick) begin
        idx   <= idx + IDX_W'(1);
        state <= (BLANK_CYC == 0) ? SHOW : BLANK;
      end else if ((state == BLANK) && blank_end) begin
        state <= SHOW;
      end
    end
  end

  // Pending buffer fill on handshake, and commit to the active value at frame end.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_full <= 1'b0;
      act_val   <= '0;
      act_dp    <= '0;
    end else begin
      // Accept needs an empty buffer and commit a full one, so they never coincide.
      if (wr_valid && !pend_full) begin
        pend_val  <= wr_data;
        pend_dp   <= wr_dp;
        pend_full <= 1'b1;
      end else if (frame_end && pend_full) begin
        act_val   <= pend_val;
        act_dp    <= pend_dp;
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_svn_scan_ctrl.sv
// Directed bench for svn_scan_ctrl with TICK_DIV=4, BLANK_CYC=1 (frame = 32 cycles).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised by holding wr_valid high with changing data while full.
module tb_svn_scan_ctrl;

  localparam int TD = 4;
  localparam int BC = 1;

  logic        clk       = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        wr_valid  = 1'b0;
  logic [31:0] wr_data   = '0;
  logic [7:0]  wr_dp     = '0;
  logic        blank_lz  = 1'b0;
  logic        wr_ready;
  logic [3:0]  digit;
  logic        dp_n;
  logic [7:0]  AN;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int drv_ok = 0;

  always #5 clk = ~clk;

  svn_scan_ctrl #(
    .TICK_DIV  (TD),
    .BLANK_CYC (BC)
  ) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .blank_lz   (blank_lz),
    .digit      (digit),
    .dp_n       (dp_n),
    .AN         (AN),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a frame_done pulse; returns sampled just after that edge.
  task automatic wait_frame(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 80 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (frame_done) seen = 1;
    end
    chk({tag, " frame_done seen"}, seen, 1);
  endtask

  // Walk one full frame starting right after a frame_done sample.
  // lit gives, per digit, whether the slot should light at all.
  task automatic scan_frame(input string tag, input logic [31:0] val,
                            input logic [7:0] dpm, input logic [7:0] lit);
    int         on_cnt;
    int         off_cnt;
    logic [7:0] exp_an;
    logic       exp_dp;
    logic [3:0] exp_dig;
    for (int s = 0; s < 8; s++) begin
      on_cnt  = 0;
      off_cnt = 0;
      exp_an  = ~(8'h01 << s);
      exp_dp  = ~dpm[s];
      exp_dig = val[4*s +: 4];
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        chk($sformatf("%s fd s%0d c%0d", tag, s, c), frame_done, (s == 7 && c == 3));
        if (AN == 8'hFF) off_cnt++; else on_cnt++;
        if (c == 0 || !lit[s]) begin
          chk($sformatf("%s an_off s%0d c%0d", tag, s, c), AN, 8'hFF);
          chk($sformatf("%s dp_off s%0d c%0d", tag, s, c), dp_n, 1'b1);
        end else begin
          chk($sformatf("%s an s%0d c%0d", tag, s, c), AN, exp_an);
          chk($sformatf("%s digit s%0d c%0d", tag, s, c), digit, exp_dig);
          chk($sformatf("%s dp s%0d c%0d", tag, s, c), dp_n, exp_dp);
        end
      end
      chk($sformatf("%s on_cycles s%0d", tag, s), on_cnt, lit[s] ? 3 : 0);
      chk($sformatf("%s off_cycles s%0d", tag, s), off_cnt, lit[s] ? 1 : 4);
    end
  endtask

  initial begin
    int rdy_bad;
    int seen;

    // Reset held for three cycles.
    sys_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst AN", AN, 8'hFF);
    chk("rst dp_n", dp_n, 1'b1);
    chk("rst digit", digit, 4'h0);
    chk("rst frame_done", frame_done, 1'b0);
    chk("rst wr_ready", wr_ready, 1'b1);
    @(negedge clk) sys_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst blank AN", AN, 8'hFF);
    @(posedge clk); #1;
    chk("first show AN", AN, 8'hFE);
    chk("first show digit", digit, 4'h0);
    chk("first show dp_n", dp_n, 1'b1);

    // Single write; ready stays low until the commit at the next frame end.
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 32'h8765_4321;
    wr_dp    = 8'h01;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    chk("after accept wr_ready", wr_ready, 1'b0);
    rdy_bad = 0;
    seen    = 0;
    for (int i = 0; i < 80 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (frame_done) seen = 1;
      else if (wr_ready) rdy_bad++;
    end
    chk("commit frame_done seen", seen, 1);
    chk("wr_ready held low", rdy_bad, 0);
    chk("wr_ready after commit", wr_ready, 1'b1);
    scan_frame("f1", 32'h8765_4321, 8'h01, 8'hFF);

    // Back-pressure: first value sticks, junk ignored, second accepted after frame_done.
    blank_lz = 1'b1;
    fork
      begin
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = 32'h0000_00A5;
        wr_dp    = 8'h02;
        @(posedge clk);
        for (int i = 0; i < 80 && drv_ok == 0; i++) begin
          @(negedge clk);
          if (wr_ready) begin
            wr_data = 32'h0000_0000;
            wr_dp   = 8'h80;
            @(posedge clk);
            drv_ok = 1;
            @(negedge clk);
            wr_valid = 1'b0;
          end else begin
            wr_data = 32'hDEAD_0000 + 32'(i);
            wr_dp   = 8'hFF;
          end
        end
      end
      begin
        scan_frame("f2_old", 32'h8765_4321, 8'h01, 8'hFF);
        scan_frame("f3_a5", 32'h0000_00A5, 8'h02, 8'h03);
      end
    join
    chk("second write accepted", drv_ok, 1);
    scan_frame("f4_zero", 32'h0000_0000, 8'h80, 8'h01);

    // Mid-frame reset with a write pending.
    blank_lz = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 32'h1234_5678;
    wr_dp    = 8'hFF;
    @(posedge clk); #1;
    chk("pend wr_ready", wr_ready, 1'b0);
    @(negedge clk) wr_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("slot4 AN", AN, 8'hEF);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async rst AN", AN, 8'hFF);
    chk("async rst dp_n", dp_n, 1'b1);
    chk("async rst digit", digit, 4'h0);
    chk("async rst frame_done", frame_done, 1'b0);
    chk("async rst wr_ready", wr_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) sys_rst_n = 1'b1;
    #1;
    chk("release wr_ready", wr_ready, 1'b1);
    @(posedge clk); #1;
    chk("release blank AN", AN, 8'hFF);
    @(posedge clk); #1;
    chk("release show AN", AN, 8'hFE);
    chk("release show digit", digit, 4'h0);
    wait_frame("release");
    scan_frame("post_rst", 32'h0000_0000, 8'h00, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
